// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared constants and types for the on-chip RAM arbiter
// Contents: MEM_ADDR_W / MEM_DATA_W / MEM_BE_W geometry of the 4096x32 RAM,
//           port_idx_t 1-bit requester index.
package onchip_mem_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = 4;

    typedef logic [0:0] port_idx_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// rtl/onchip_mem_arbiter_if.sv - Avalon-MM style requester port bundle
// Signals: address, byteenable, read, write, writedata (requester -> arbiter);
//          waitrequest, readdata, readdatavalid (arbiter -> requester).
// Modports: master = requester side, slave = arbiter side.
interface onchip_mem_arbiter_if
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);

    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin / fixed-priority arbiter
// Ports: clk, reset_n (sync active-low), req[1:0] in, grant[1:0] one-hot out.
// Grant is combinational; last_grant advances whenever a grant is issued.
module rr_arb2
    import onchip_mem_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    port_idx_t last_grant;

    always_comb begin
        grant = 2'b00;
        if (reset_n) begin
            if (req == 2'b11) begin
                // Conflict: fixed mode favours requester 0, otherwise the
                // requester that did not win last time.
                if (FIXED_PRIO != 0 || last_grant == 1'b1) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end else begin
                grant = req;
            end
        end
    end

    // Reset to 1 so requester 0 wins the first conflict after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-port arbiter in front of a 4096x32 single-port RAM
// Ports: clk, reset_n (sync active-low);
//        p0, p1 : Avalon-MM slave ports (onchip_mem_arbiter_if.slave);
//        mem_address/byteenable/chipselect/write/writedata/clken out to the RAM,
//        mem_readdata in from the RAM (1-cycle read latency).
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    onchip_mem_arbiter_if.slave   p0,
    onchip_mem_arbiter_if.slave   p1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    logic [1:0] req;
    logic [1:0] grant;
    logic       rd_accept;
    logic       rd_vld;
    port_idx_t  rd_port;

    assign req[0] = p0.read | p0.write;
    assign req[1] = p1.read | p1.write;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant)
    );

    assign p0.waitrequest = ~reset_n | (req[0] & ~grant[0]);
    assign p1.waitrequest = ~reset_n | (req[1] & ~grant[1]);

    // With no grant the p0 side is passed through; chipselect keeps it inert.
    always_comb begin
        mem_address    = p0.address;
        mem_byteenable = p0.byteenable;
        mem_writedata  = p0.writedata;
        if (grant[1]) begin
            mem_address    = p1.address;
            mem_byteenable = p1.byteenable;
            mem_writedata  = p1.writedata;
        end
    end

    assign mem_chipselect = |grant;
    assign mem_write      = (grant[0] & p0.write) | (grant[1] & p1.write);
    assign mem_clken      = 1'b1;

    // Read+write together is treated as a write, so it never returns data.
    assign rd_accept = (grant[0] & p0.read & ~p0.write)
                     | (grant[1] & p1.read & ~p1.write);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_vld  <= 1'b0;
            rd_port <= 1'b0;
        end else begin
            rd_vld <= rd_accept;
            if (rd_accept) begin
                rd_port <= grant[1];
            end
        end
    end

    // reset_n gating kills a read still in flight when reset arrives.
    assign p0.readdatavalid = reset_n & rd_vld & (rd_port == 1'b0);
    assign p1.readdatavalid = reset_n & rd_vld & (rd_port == 1'b1);
    assign p0.readdata      = mem_readdata;
    assign p1.readdata      = mem_readdata;

    assert property (@(posedge clk) disable iff (!reset_n) !(p0.read && p0.write))
        else $error("onchip_mem_arbiter: p0 read and write asserted together");
    assert property (@(posedge clk) disable iff (!reset_n) !(p1.read && p1.write))
        else $error("onchip_mem_arbiter: p1 read and write asserted together");

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - self-checking bench for onchip_mem_arbiter
module tb_onchip_mem_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus, driven into both DUT instances (round-robin and fixed).
    logic        dr [2];
    logic        dw [2];
    logic [11:0] da [2];
    logic [31:0] dd [2];
    logic [3:0]  db [2];

    onchip_mem_arbiter_if p0a ();
    onchip_mem_arbiter_if p1a ();
    onchip_mem_arbiter_if p0b ();
    onchip_mem_arbiter_if p1b ();

    assign p0a.read = dr[0];  assign p0a.write = dw[0];  assign p0a.address = da[0];
    assign p0a.writedata = dd[0];  assign p0a.byteenable = db[0];
    assign p1a.read = dr[1];  assign p1a.write = dw[1];  assign p1a.address = da[1];
    assign p1a.writedata = dd[1];  assign p1a.byteenable = db[1];
    assign p0b.read = dr[0];  assign p0b.write = dw[0];  assign p0b.address = da[0];
    assign p0b.writedata = dd[0];  assign p0b.byteenable = db[0];
    assign p1b.read = dr[1];  assign p1b.write = dw[1];  assign p1b.address = da[1];
    assign p1b.writedata = dd[1];  assign p1b.byteenable = db[1];

    logic [11:0] ma [2];
    logic [3:0]  mb [2];
    logic        mcs [2];
    logic        mwe [2];
    logic [31:0] mwd [2];
    logic        mck [2];
    logic [31:0] mrd [2];

    onchip_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .FIXED_PRIO(0)) u0 (
        .clk(clk), .reset_n(reset_n), .p0(p0a), .p1(p1a),
        .mem_address(ma[0]), .mem_byteenable(mb[0]), .mem_chipselect(mcs[0]),
        .mem_write(mwe[0]), .mem_writedata(mwd[0]), .mem_clken(mck[0]),
        .mem_readdata(mrd[0])
    );

    onchip_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .FIXED_PRIO(1)) u1 (
        .clk(clk), .reset_n(reset_n), .p0(p0b), .p1(p1b),
        .mem_address(ma[1]), .mem_byteenable(mb[1]), .mem_chipselect(mcs[1]),
        .mem_write(mwe[1]), .mem_writedata(mwd[1]), .mem_clken(mck[1]),
        .mem_readdata(mrd[1])
    );

    // RAM models: registered address, unregistered read data, byte-lane writes.
    logic [31:0] ram0 [4096];
    logic [31:0] ram1 [4096];
    logic [11:0] aq [2];

    always @(posedge clk) begin
        if (mcs[0] && mwe[0])
            for (int b = 0; b < 4; b++)
                if (mb[0][b]) ram0[ma[0]][8*b +: 8] <= mwd[0][8*b +: 8];
        if (mck[0]) aq[0] <= ma[0];
    end

    always @(posedge clk) begin
        if (mcs[1] && mwe[1])
            for (int b = 0; b < 4; b++)
                if (mb[1][b]) ram1[ma[1]][8*b +: 8] <= mwd[1][8*b +: 8];
        if (mck[1]) aq[1] <= ma[1];
    end

    assign mrd[0] = ram0[aq[0]];
    assign mrd[1] = ram1[aq[1]];

    // Observed per-instance port outputs.
    logic ow0 [2];
    logic ow1 [2];
    logic ov0 [2];
    logic ov1 [2];
    logic [31:0] od0 [2];
    logic [31:0] od1 [2];
    assign ow0[0] = p0a.waitrequest;   assign ow1[0] = p1a.waitrequest;
    assign ov0[0] = p0a.readdatavalid; assign ov1[0] = p1a.readdatavalid;
    assign od0[0] = p0a.readdata;      assign od1[0] = p1a.readdata;
    assign ow0[1] = p0b.waitrequest;   assign ow1[1] = p1b.waitrequest;
    assign ov0[1] = p0b.readdatavalid; assign ov1[1] = p1b.readdatavalid;
    assign od0[1] = p0b.readdata;      assign od1[1] = p1b.readdata;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // One clock cycle: drive after the rising edge, return at the falling edge.
    task automatic cyc(input bit rst,
                       input logic r0, input logic w0, input logic [11:0] a0,
                       input logic [31:0] d0, input logic [3:0] b0,
                       input logic r1, input logic w1, input logic [11:0] a1,
                       input logic [31:0] d1, input logic [3:0] b1);
        @(posedge clk);
        #1;
        reset_n = ~rst;
        dr[0] = r0; dw[0] = w0; da[0] = a0; dd[0] = d0; db[0] = b0;
        dr[1] = r1; dw[1] = w1; da[1] = a1; dd[1] = d1; db[1] = b1;
        @(negedge clk);
    endtask

    task automatic idle(input bit rst);
        cyc(rst, 0, 0, 12'h0, 32'h0, 4'h0, 0, 0, 12'h0, 32'h0, 4'h0);
    endtask

    typedef struct {
        bit          rst;
        logic        r0, w0;
        logic [11:0] a0;
        logic [31:0] d0;
        logic [3:0]  b0;
        logic        r1, w1;
        logic [11:0] a1;
        logic [31:0] d1;
        logic [3:0]  b1;
        logic        ew0, ew1, ecs, ewe;
        logic [11:0] ema;
        logic        erv0, erv1;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(bit rst, logic r0, logic w0, logic [11:0] a0, logic [31:0] d0,
                                logic [3:0] b0, logic r1, logic w1, logic [11:0] a1,
                                logic [31:0] d1, logic ew0, logic ew1, logic ecs, logic ewe,
                                logic [11:0] ema, logic erv0, logic erv1, logic [31:0] erd);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.b0 = b0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.b1 = 4'hF;
        v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs; v.ewe = ewe; v.ema = ema;
        v.erv0 = erv0; v.erv1 = erv1; v.erd = erd;
        return v;
    endfunction

    vec_t vt [17];

    // Reference model state for the random phase (index = instance).
    bit          m_last [2];
    bit          m_pv [2];
    bit          m_pp [2];
    logic [31:0] m_pd [2];
    logic [31:0] smem [2][8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, k1c0, k1c1;
        //            rst r0 w0 a0      d0            b0    r1 w1 a1      d1            ew0 ew1 cs we ma      rv0 rv1 rd
        vt[0]  = mk(0, 0, 1, 12'h005, 32'hDEADBEEF, 4'hF, 0, 0, 12'h000, 32'h0,        0, 0, 1, 1, 12'h005, 0, 0, 32'h0);
        vt[1]  = mk(0, 1, 0, 12'h005, 32'h0,        4'hF, 0, 0, 12'h000, 32'h0,        0, 0, 1, 0, 12'h005, 0, 0, 32'h0);
        vt[2]  = mk(0, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 12'h000, 1, 0, 32'hDEADBEEF);
        vt[3]  = mk(0, 0, 1, 12'hFFF, 32'h11223344, 4'hF, 0, 0, 12'h000, 32'h0,        0, 0, 1, 1, 12'hFFF, 0, 0, 32'h0);
        vt[4]  = mk(0, 0, 1, 12'hFFF, 32'hAA000000, 4'h8, 0, 0, 12'h000, 32'h0,        0, 0, 1, 1, 12'hFFF, 0, 0, 32'h0);
        vt[5]  = mk(0, 1, 0, 12'hFFF, 32'h0,        4'hF, 0, 0, 12'h000, 32'h0,        0, 0, 1, 0, 12'hFFF, 0, 0, 32'h0);
        vt[6]  = mk(0, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 12'h000, 1, 0, 32'hAA223344);
        vt[7]  = mk(1, 1, 0, 12'h005, 32'h0,        4'hF, 1, 0, 12'h100, 32'h0,        1, 1, 0, 0, 12'h000, 0, 0, 32'h0);
        vt[8]  = mk(0, 0, 1, 12'h100, 32'h5A5A5A5A, 4'hF, 1, 0, 12'h100, 32'h0,        0, 1, 1, 1, 12'h100, 0, 0, 32'h0);
        vt[9]  = mk(0, 0, 0, 12'h000, 32'h0,        4'h0, 1, 0, 12'h100, 32'h0,        0, 0, 1, 0, 12'h100, 0, 0, 32'h0);
        vt[10] = mk(0, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 12'h000, 0, 1, 32'h5A5A5A5A);
        vt[11] = mk(0, 0, 0, 12'h000, 32'h0,        4'h0, 1, 0, 12'h005, 32'h0,        0, 0, 1, 0, 12'h005, 0, 0, 32'h0);
        vt[12] = mk(1, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        1, 1, 0, 0, 12'h000, 0, 0, 32'h0);
        vt[13] = mk(0, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 12'h000, 0, 0, 32'h0);
        vt[14] = mk(0, 1, 0, 12'h005, 32'h0,        4'hF, 1, 0, 12'h100, 32'h0,        0, 1, 1, 0, 12'h005, 0, 0, 32'h0);
        vt[15] = mk(0, 1, 0, 12'h005, 32'h0,        4'hF, 1, 0, 12'h100, 32'h0,        1, 0, 1, 0, 12'h100, 1, 0, 32'hDEADBEEF);
        vt[16] = mk(0, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 12'h000, 0, 1, 32'h5A5A5A5A);

        // Reset state.
        idle(1);
        idle(1);
        chk("reset_wait0", 32'(ow0[0]), 32'd1);
        chk("reset_wait1", 32'(ow1[0]), 32'd1);
        chk("reset_cs", 32'(mcs[0]), 32'd0);
        chk("reset_rdv", 32'({ov0[0], ov1[0]}), 32'd0);

        // Directed table on the round-robin instance.
        foreach (vt[i]) begin
            cyc(vt[i].rst, vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].b0,
                vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1, vt[i].b1);
            chk($sformatf("v%0d_wait0", i), 32'(ow0[0]), 32'(vt[i].ew0));
            chk($sformatf("v%0d_wait1", i), 32'(ow1[0]), 32'(vt[i].ew1));
            chk($sformatf("v%0d_cs", i), 32'(mcs[0]), 32'(vt[i].ecs));
            chk($sformatf("v%0d_we", i), 32'(mwe[0]), 32'(vt[i].ewe));
            if (vt[i].ecs) chk($sformatf("v%0d_addr", i), 32'(ma[0]), 32'(vt[i].ema));
            chk($sformatf("v%0d_rdv0", i), 32'(ov0[0]), 32'(vt[i].erv0));
            chk($sformatf("v%0d_rdv1", i), 32'(ov1[0]), 32'(vt[i].erv1));
            if (vt[i].erv0) chk($sformatf("v%0d_rdata0", i), od0[0], vt[i].erd);
            if (vt[i].erv1) chk($sformatf("v%0d_rdata1", i), od1[0], vt[i].erd);
        end

        // Both ports reading every cycle after reset: RR alternates, fixed favours p0.
        cyc(0, 0, 1, 12'h010, 32'h11110010, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
        cyc(0, 0, 1, 12'h020, 32'h22220020, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
        idle(1);
        c0 = 0; c1 = 0; k1c0 = 0; k1c1 = 0;
        for (int c = 0; c < 8; c++) begin
            if (c < 6)       cyc(0, 1, 0, 12'h010, 32'h0, 4'hF, 1, 0, 12'h020, 32'h0, 4'hF);
            else if (c == 6) cyc(0, 0, 0, 12'h000, 32'h0, 4'h0, 1, 0, 12'h020, 32'h0, 4'hF);
            else             idle(0);
            if (c < 6) begin
                chk($sformatf("rr%0d_wait0", c), 32'(ow0[0]), 32'(c % 2));
                chk($sformatf("rr%0d_wait1", c), 32'(ow1[0]), 32'((c + 1) % 2));
                chk($sformatf("fx%0d_wait0", c), 32'(ow0[1]), 32'd0);
                chk($sformatf("fx%0d_wait1", c), 32'(ow1[1]), 32'd1);
            end
            if (c == 6) chk("fx_p1_after_drop", 32'(ow1[1]), 32'd0);
            if (ov0[0]) begin c0++;   chk($sformatf("rr%0d_data0", c), od0[0], 32'h11110010); end
            if (ov1[0]) begin c1++;   chk($sformatf("rr%0d_data1", c), od1[0], 32'h22220020); end
            if (ov0[1]) begin k1c0++; chk($sformatf("fx%0d_data0", c), od0[1], 32'h11110010); end
            if (ov1[1]) begin k1c1++; chk($sformatf("fx%0d_data1", c), od1[1], 32'h22220020); end
        end
        chk("rr_count0", 32'(c0), 32'd3);
        chk("rr_count1", 32'(c1), 32'd4);
        chk("fx_count0", 32'(k1c0), 32'd6);
        chk("fx_count1", 32'(k1c1), 32'd1);

        // Random traffic against the reference model, both instances.
        idle(1);
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1'b1;
            m_pv[k]   = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            logic        r [2];
            logic        w [2];
            logic [11:0] a [2];
            logic [31:0] d [2];
            logic [3:0]  b [2];
            for (int p = 0; p < 2; p++) begin
                int op;
                op   = (c < 8) ? ((p == 0) ? 2 : 0) : int'($urandom_range(0, 2));
                r[p] = (op == 1);
                w[p] = (op == 2);
                a[p] = (c < 8) ? 12'(c) : 12'($urandom_range(0, 7));
                d[p] = $urandom;
                b[p] = (c < 8) ? 4'hF : 4'($urandom_range(1, 15));
            end
            cyc(0, r[0], w[0], a[0], d[0], b[0], r[1], w[1], a[1], d[1], b[1]);
            for (int k = 0; k < 2; k++) begin
                bit req0, req1, any, win;
                req0 = r[0] | w[0];
                req1 = r[1] | w[1];
                any  = req0 | req1;
                if (req0 && req1) win = (k == 1) ? 1'b0 : ~m_last[k];
                else              win = req0 ? 1'b0 : 1'b1;
                chk($sformatf("rnd%0d_k%0d_wait0", c, k), 32'(ow0[k]), 32'(req0 && !(any && win == 1'b0)));
                chk($sformatf("rnd%0d_k%0d_wait1", c, k), 32'(ow1[k]), 32'(req1 && !(any && win == 1'b1)));
                chk($sformatf("rnd%0d_k%0d_rdv0", c, k), 32'(ov0[k]), 32'(m_pv[k] && m_pp[k] == 1'b0));
                chk($sformatf("rnd%0d_k%0d_rdv1", c, k), 32'(ov1[k]), 32'(m_pv[k] && m_pp[k] == 1'b1));
                if (m_pv[k]) chk($sformatf("rnd%0d_k%0d_rdata", c, k), od0[k], m_pd[k]);
                m_pv[k] = 1'b0;
                if (any) begin
                    m_last[k] = win;
                    if (r[win]) begin
                        m_pv[k] = 1'b1;
                        m_pp[k] = win;
                        m_pd[k] = smem[k][a[win][2:0]];
                    end else begin
                        for (int bl = 0; bl < 4; bl++)
                            if (b[win][bl]) smem[k][a[win][2:0]][8*bl +: 8] = d[win][8*bl +: 8];
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master arbiter for the 4096x32 single-port on-chip RAM (byte-enabled, 1-cycle read latency: address registered in the RAM, output unregistered).
- Presents two Avalon-MM slave ports (p0, p1) with waitrequest/readdatavalid and drives the RAM's single s1-style port.
- Round-robin by default; fixed priority (p0 wins) is selectable.
- One transfer is issued to the RAM per cycle, fully pipelined.

Parameters:
- ADDR_W, 12, word address width (RAM depth 2^ADDR_W = 4096).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- FIXED_PRIO, 0, 0 = round-robin; 1 = p0 always wins a conflict.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- p0_address  in  ADDR_W  port 0 word address
- p0_byteenable  in  DATA_W/8  port 0 byte lanes
- p0_read  in  1  port 0 read request
- p0_write  in  1  port 0 write request
- p0_writedata  in  DATA_W  port 0 write data
- p0_waitrequest  out  1  port 0 stall
- p0_readdata  out  DATA_W  port 0 read data
- p0_readdatavalid  out  1  port 0 read data strobe
- p1_*  same eight signals for port 1
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken
- mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Request: req_i = pi_read | pi_write.
- Grant is combinational from req0, req1, the reset_n state and the last_grant register:
  - only one port requesting -> that port is granted;
  - both requesting, FIXED_PRIO=1 -> p0;
  - both requesting, round-robin -> the port that is not last_grant.
- pi_waitrequest = req_i & ~grant_i, or 1 while reset_n=0. An idle port sees waitrequest=0.
- A transfer is accepted in any cycle where req_i & grant_i.
- Memory outputs are combinational muxes of the granted port:
  - mem_chipselect = any grant;
  - mem_write = granted port's write.
  - With no grant, mem_address, mem_byteenable and mem_writedata hold the p0 values (don't-care) and chipselect/write = 0.
- mem_clken is tied 1; no stalling of the RAM pipeline.
- Read pipeline: registered rd_vld and rd_port, set on an accepted read.
  - Next cycle: pi_readdatavalid = rd_vld & (rd_port==i).
  - pi_readdata = mem_readdata on both ports (broadcast; qualified only by readdatavalid).
  - Read latency is exactly 1 cycle after acceptance. Back-to-back reads give 1 readdatavalid per cycle, in acceptance order.
- Writes have zero response; the data is in the RAM at the accepting edge. A read to the same address in the next cycle returns the new data.
- last_grant updates only on an accepted transfer.
- Read and write asserted together on one port is illegal. The RTL treats it as a write: no readdatavalid is produced. Simulation flags it with an error message.
- Reset (reset_n=0 at a clk edge):
  - rd_vld=0, rd_port=0, last_grant=1, so p0 wins the first conflict.
  - While reset_n=0: both waitrequest=1, mem_chipselect=0, mem_write=0, readdatavalid=0.
  - A read accepted in the cycle before reset asserts produces no readdatavalid if reset_n=0 at the following edge.
- Throughput: a conflict alternates p0/p1 every cycle (round-robin). No starvation; worst-case wait is 1 cycle.

Decomposition:
- Shared package onchip_mem_pkg:
  - constants MEM_ADDR_W=12, MEM_DATA_W=32, MEM_BE_W=4;
  - a port-index typedef (1 bit).
- Natural sub-module rr_arb2: 2-requester round-robin arbiter with a FIXED_PRIO parameter, the last_grant register and a one-hot grant output. Reused by other shared-resource blocks.
- The rest (mux, read tag pipeline) is flat in onchip_mem_arbiter.

Test Plan:
- p0 write addr 0x005 data 0xDEADBEEF be 0xF, then p0 read 0x005 -> p0_waitrequest=0 both cycles; p0_readdatavalid=1 exactly 1 cycle after the read, readdata 0xDEADBEEF; p1_readdatavalid stays 0.
- Byte lanes: write 0x11223344 be 0xF, then 0xAA000000 be 0x8 to addr 0xFFF, then read -> 0xAA223344.
- Both ports read every cycle for 6 cycles after reset (p0 addr 0x010, p1 addr 0x020, preloaded) -> grants p0,p1,p0,p1,p0,p1; each port gets 3 readdatavalids with its own data; waitrequest toggles opposite each cycle.
- Same stimulus with FIXED_PRIO=1 -> p0 granted all 6 cycles, p1_waitrequest=1 throughout; after p0 drops, p1 granted on the next cycle.
- Conflicting write/read: p0 write 0x100=0x5A5A5A5A while p1 reads 0x100 in the same cycle (p0 wins after reset) -> p1 accepted the next cycle, returns 0x5A5A5A5A.
- Reset mid-op: accept a p1 read, drive reset_n=0 at the next edge -> no p1_readdatavalid. During reset, both waitrequest=1 and mem_chipselect=0. First conflict after release is granted to p0.
